// File: rtl/mips_pkg.sv
// Shared encodings and types for the multi-cycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  // Retire counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU: add/sub/and/or and signed set-less-than.
module mips_alu
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_op_t               op,
  output logic [DATA_WIDTH-1:0] y
);

  // Select the operation; wrap-around arithmetic discards carries.
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core with loadable instruction memory.
//
// state  | meaning
// IDLE   | after reset; IM writable, waiting for start
// FETCH  | IR <= IM[pc], pc advances
// DECODE | operand registers loaded from the register file
// EXEC   | ALU result captured, or branch/jump/halt/nop resolved and retired
// WB     | register file written, ALU/ADDI instruction retires
// HALT   | program finished; IM writable, start reruns from pc 0
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int IM_ADDRESS_WIDTH  = 6,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int RF_ADDRESS_WIDTH  = 5,
  parameter int DATA_WIDTH        = 16
) (
  input  logic                         clk,
  input  logic                         asyn_n_rst,
  input  logic                         im_we,
  input  logic [IM_ADDRESS_WIDTH-1:0]  im_waddr,
  input  logic [INSTRUCTION_WIDTH-1:0] im_wdata,
  input  logic                         start,
  output logic                         busy,
  output logic                         halted,
  output logic [IM_ADDRESS_WIDTH-1:0]  pc,
  output logic [DATA_WIDTH-1:0]        result,
  output logic                         result_valid,
  output logic [15:0]                  instr_count
);

  localparam int IM_DEPTH = 2 ** IM_ADDRESS_WIDTH;
  localparam int RF_DEPTH = 2 ** RF_ADDRESS_WIDTH;

  logic [INSTRUCTION_WIDTH-1:0] im [IM_DEPTH];
  logic [DATA_WIDTH-1:0]        rf [RF_DEPTH];

  state_t                       state;
  logic [INSTRUCTION_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0]        reg_a;
  logic [DATA_WIDTH-1:0]        reg_b;
  logic [RF_ADDRESS_WIDTH-1:0]  wb_dest;

  logic [5:0]                   opcode;
  logic [5:0]                   funct;
  logic [RF_ADDRESS_WIDTH-1:0]  rs_idx;
  logic [RF_ADDRESS_WIDTH-1:0]  rt_idx;
  logic [RF_ADDRESS_WIDTH-1:0]  rd_idx;
  logic [31:0]                  imm32;
  logic [DATA_WIDTH-1:0]        imm_data;
  logic [IM_ADDRESS_WIDTH-1:0]  imm_pc;

  alu_op_t                      alu_op;
  logic [DATA_WIDTH-1:0]        alu_b;
  logic [DATA_WIDTH-1:0]        alu_y;
  logic                         writes_rf;
  logic [RF_ADDRESS_WIDTH-1:0]  dest;
  logic                         is_beq;
  logic                         is_j;
  logic                         is_halt;
  logic                         loadable;

  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
  assign rs_idx   = ir[21 +: RF_ADDRESS_WIDTH];
  assign rt_idx   = ir[16 +: RF_ADDRESS_WIDTH];
  assign rd_idx   = ir[11 +: RF_ADDRESS_WIDTH];
  assign imm32    = {{16{ir[15]}}, ir[15:0]};
  assign imm_data = imm32[DATA_WIDTH-1:0];
  assign imm_pc   = imm32[IM_ADDRESS_WIDTH-1:0];
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);
  assign is_halt  = (opcode == OP_HALT);
  assign loadable = (state == S_IDLE) || (state == S_HALT);

  // Instruction decode for the ALU path; unknown funct/opcode falls through as a NOP.
  always_comb begin
    alu_op    = ALU_ADD;
    alu_b     = reg_b;
    writes_rf = 1'b0;
    dest      = rd_idx;
    case (opcode)
      OP_RTYPE: begin
        writes_rf = 1'b1;
        case (funct)
          F_ADD:   alu_op = ALU_ADD;
          F_SUB:   alu_op = ALU_SUB;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_SLT:   alu_op = ALU_SLT;
          default: writes_rf = 1'b0;
        endcase
      end
      OP_ADDI: begin
        alu_b     = imm_data;
        dest      = rt_idx;
        writes_rf = 1'b1;
      end
      default: writes_rf = 1'b0;
    endcase
  end

  mips_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a  (reg_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  // Instruction memory write port; contents survive reset and only load while stopped.
  always_ff @(posedge clk) begin
    if (im_we && loadable) begin
      im[im_waddr] <= im_wdata;
    end
  end

  // Control FSM, register file and all registered outputs.
  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      state        <= S_IDLE;
      pc           <= '0;
      ir           <= '0;
      reg_a        <= '0;
      reg_b        <= '0;
      wb_dest      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      instr_count  <= '0;
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state       <= S_FETCH;
            pc          <= '0;
            instr_count <= '0;
            halted      <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_FETCH: begin
          ir    <= im[pc];
          pc    <= pc + IM_ADDRESS_WIDTH'(1);
          state <= S_DECODE;
        end
        S_DECODE: begin
          reg_a <= (rs_idx == '0) ? '0 : rf[rs_idx];
          reg_b <= (rt_idx == '0) ? '0 : rf[rt_idx];
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (writes_rf) begin
            result       <= alu_y;
            result_valid <= 1'b1;
            wb_dest      <= dest;
            state        <= S_WB;
          end else begin
            instr_count <= sat_inc16(instr_count);
            if (is_halt) begin
              state  <= S_HALT;
              halted <= 1'b1;
              busy   <= 1'b0;
            end else begin
              state <= S_FETCH;
              if (is_beq && (reg_a == reg_b)) begin
                pc <= pc + imm_pc;
              end else if (is_j) begin
                pc <= ir[IM_ADDRESS_WIDTH-1:0];
              end
            end
          end
        end
        S_WB: begin
          if (wb_dest != '0) begin
            rf[wb_dest] <= result;
          end
          instr_count <= sat_inc16(instr_count);
          state       <= S_FETCH;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: table vectors, directed
// sequences and random programs checked against an instruction-level model.
module tb_mips_multicycle_core;

  localparam int IMW      = 6;
  localparam int DW       = 16;
  localparam int IM_DEPTH = 64;
  localparam logic [31:0] HALT_W = {6'h3F, 26'd0};

  logic            clk;
  logic            asyn_n_rst;
  logic            im_we;
  logic [IMW-1:0]  im_waddr;
  logic [31:0]     im_wdata;
  logic            start;
  logic            busy;
  logic            halted;
  logic [IMW-1:0]  pc;
  logic [DW-1:0]   result;
  logic            result_valid;
  logic [15:0]     instr_count;

  mips_multicycle_core #(
    .IM_ADDRESS_WIDTH (IMW),
    .INSTRUCTION_WIDTH(32),
    .RF_ADDRESS_WIDTH (5),
    .DATA_WIDTH       (DW)
  ) dut (
    .clk          (clk),
    .asyn_n_rst   (asyn_n_rst),
    .im_we        (im_we),
    .im_waddr     (im_waddr),
    .im_wdata     (im_wdata),
    .start        (start),
    .busy         (busy),
    .halted       (halted),
    .pc           (pc),
    .result       (result),
    .result_valid (result_valid),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] tb_im [IM_DEPTH];
  logic [15:0] strobe_v [$];
  int          strobe_c [$];
  logic [5:0]  pc_log [$];
  int          halt_cyc;
  logic        busy_c1;

  logic [15:0] exp_v [$];
  int          exp_c [$];
  int          exp_fc [$];
  int          exp_fpc [$];
  int          exp_count;
  int          exp_halt;
  logic [15:0] m_rf [32];

  typedef struct {
    logic [5:0]  funct;
    logic [15:0] a;
    logic [15:0] b;
    bit          has_wb;
    logic [15:0] expv;
  } vec_t;
  vec_t vt [10];

  logic [5:0] fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] f);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, f};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(int target);
    return {6'b000010, 26'(target)};
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endfunction

  task automatic do_reset();
    asyn_n_rst = 1'b0;
    start      = 1'b0;
    im_we      = 1'b0;
    @(negedge clk);
    asyn_n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_word(input int addr, input logic [31:0] w);
    im_we    = 1'b1;
    im_waddr = 6'(addr);
    im_wdata = w;
    tb_im[addr] = w;
    @(negedge clk);
    im_we = 1'b0;
  endtask

  // Instruction-set level model: walks the program word by word from pc 0.
  task automatic model_run(input bit clear_rf);
    int p;
    int t;
    int dest;
    bit wr;
    logic [31:0] w;
    logic [15:0] a, b, v, imm;
    logic [5:0] op, f;
    if (clear_rf) foreach (m_rf[i]) m_rf[i] = '0;
    exp_v.delete(); exp_c.delete(); exp_fc.delete(); exp_fpc.delete();
    exp_count = 0;
    exp_halt  = -1;
    p = 0;
    t = 0;
    for (int step = 0; step < 500; step++) begin
      w   = tb_im[p];
      op  = w[31:26];
      f   = w[5:0];
      imm = w[15:0];
      exp_fc.push_back(t + 1);
      exp_fpc.push_back(p);
      a = m_rf[w[25:21]];
      b = m_rf[w[20:16]];
      p = (p + 1) % IM_DEPTH;
      exp_count++;
      wr = 0; dest = 0; v = '0;
      if (op == 6'h00) begin
        dest = int'(w[15:11]);
        wr = 1;
        case (f)
          6'h20: v = a + b;
          6'h22: v = a - b;
          6'h24: v = a & b;
          6'h25: v = a | b;
          6'h2A: v = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
          default: wr = 0;
        endcase
      end else if (op == 6'h08) begin
        dest = int'(w[20:16]);
        wr = 1;
        v = a + imm;
      end else if (op == 6'h04) begin
        if (a == b) p = (p + int'($signed(imm))) & (IM_DEPTH - 1);
      end else if (op == 6'h02) begin
        p = int'(w[5:0]);
      end else if (op == 6'h3F) begin
        exp_halt = t + 4;
        break;
      end
      if (wr) begin
        exp_v.push_back(v);
        exp_c.push_back(t + 4);
        if (dest != 0) m_rf[dest] = v;
        t += 4;
      end else begin
        t += 3;
      end
    end
  endtask

  // Start at a negedge and watch one cycle per negedge; optional mid-run injection.
  task automatic run(input int inj_cyc, input int inj_kind, input logic [5:0] inj_addr,
                     input logic [31:0] inj_data, input int max_cyc, input bit expect_halt);
    strobe_v.delete(); strobe_c.delete(); pc_log.delete();
    pc_log.push_back('0);
    halt_cyc = -1;
    busy_c1  = 1'b0;
    start    = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      im_we = 1'b0;
      pc_log.push_back(pc);
      if (c == 1) busy_c1 = busy;
      if (result_valid) begin
        strobe_v.push_back(result);
        strobe_c.push_back(c);
      end
      if (halted) begin
        halt_cyc = c;
        break;
      end
      if (c == inj_cyc) begin
        if (inj_kind == 1) begin
          im_we = 1'b1; im_waddr = inj_addr; im_wdata = inj_data;
        end else if (inj_kind == 2) begin
          start = 1'b1;
        end else if (inj_kind == 3) begin
          #2 asyn_n_rst = 1'b0;
          break;
        end
      end
    end
    if (expect_halt) check("halt_reached", (halt_cyc >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic compare_model(input string tag);
    int n;
    check({tag, "_strobe_count"}, strobe_v.size(), exp_v.size());
    n = (strobe_v.size() < exp_v.size()) ? strobe_v.size() : exp_v.size();
    for (int k = 0; k < n; k++) begin
      check({tag, "_wb_value"}, strobe_v[k], exp_v[k]);
      check({tag, "_wb_cycle"}, strobe_c[k], exp_c[k]);
    end
    check({tag, "_instr_count"}, instr_count, exp_count);
    check({tag, "_halt_cycle"}, halt_cyc, exp_halt);
    for (int k = 0; k < exp_fc.size(); k++) begin
      if (exp_fc[k] < pc_log.size()) check({tag, "_fetch_pc"}, pc_log[exp_fc[k]], exp_fpc[k]);
    end
  endtask

  task automatic check_strobes4(input string tag);
    check({tag, "_n"}, strobe_v.size(), 4);
    if (strobe_v.size() == 4) begin
      check({tag, "_v0"}, strobe_v[0], 16'h0005);
      check({tag, "_v1"}, strobe_v[1], 16'hFFFD);
      check({tag, "_v2"}, strobe_v[2], 16'h0002);
      check({tag, "_v3"}, strobe_v[3], 16'h0001);
      check({tag, "_c0"}, strobe_c[0], 4);
      check({tag, "_c3"}, strobe_c[3], 16);
    end
    check({tag, "_count"}, instr_count, 5);
    check({tag, "_halt_cyc"}, halt_cyc, 20);
  endtask

  task automatic load_basic();
    load_word(0, enc_i(6'h08, 0, 1, 16'd5));
    load_word(1, enc_i(6'h08, 0, 2, 16'hFFFD));
    load_word(2, enc_r(1, 2, 3, 6'h20));
    load_word(3, enc_r(2, 1, 4, 6'h2A));
    load_word(4, HALT_W);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int L, kind, rs, rt, rd;

    vt[0] = '{6'h20, 16'h7FFF, 16'h0001, 1'b1, 16'h8000};
    vt[1] = '{6'h22, 16'h0003, 16'h0005, 1'b1, 16'hFFFE};
    vt[2] = '{6'h24, 16'h0F0F, 16'h00FF, 1'b1, 16'h000F};
    vt[3] = '{6'h25, 16'h0F00, 16'h00F0, 1'b1, 16'h0FF0};
    vt[4] = '{6'h2A, 16'hFFFF, 16'h0001, 1'b1, 16'h0001};
    vt[5] = '{6'h2A, 16'h0001, 16'hFFFF, 1'b1, 16'h0000};
    vt[6] = '{6'h2A, 16'h8000, 16'h7FFF, 1'b1, 16'h0001};
    vt[7] = '{6'h22, 16'h8000, 16'h0001, 1'b1, 16'h7FFF};
    vt[8] = '{6'h20, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFE};
    vt[9] = '{6'h27, 16'h1234, 16'h4321, 1'b0, 16'h0000};

    asyn_n_rst = 1'b1;
    start = 1'b0; im_we = 1'b0; im_waddr = '0; im_wdata = '0;
    #3 asyn_n_rst = 1'b0;
    @(negedge clk);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check("rst_count", instr_count, 0);
    asyn_n_rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < IM_DEPTH; i++) load_word(i, HALT_W);

    // Basic program from the plan.
    load_basic();
    do_reset();
    model_run(1);
    run(0, 0, '0, '0, 60, 1);
    check("basic_busy", busy_c1, 1);
    check("basic_pc_first_fetch", pc_log[1], 0);
    check_strobes4("basic");
    check("basic_halted", halted, 1);
    check("basic_busy_end", busy, 0);
    compare_model("basic_model");

    // Branch and jump.
    load_word(0, enc_i(6'h04, 0, 0, 16'd1));
    load_word(1, enc_i(6'h08, 0, 5, 16'd7));
    load_word(2, enc_j(4));
    load_word(3, enc_i(6'h08, 0, 6, 16'd8));
    load_word(4, HALT_W);
    do_reset();
    model_run(1);
    run(0, 0, '0, '0, 60, 1);
    check("br_no_strobe", strobe_v.size(), 0);
    check("br_count", instr_count, 3);
    check("br_pc_c4", pc_log[4], 2);
    check("br_pc_c7", pc_log[7], 4);
    check("br_final_pc", pc, 5);
    compare_model("br_model");

    // r0 writes are suppressed but still shown.
    load_word(0, enc_i(6'h08, 0, 0, 16'd9));
    load_word(1, enc_r(0, 0, 1, 6'h20));
    load_word(2, HALT_W);
    do_reset();
    run(0, 0, '0, '0, 60, 1);
    check("r0_n", strobe_v.size(), 2);
    if (strobe_v.size() == 2) begin
      check("r0_first", strobe_v[0], 9);
      check("r0_second", strobe_v[1], 0);
    end

    // Signed overflow wraps.
    load_word(0, enc_i(6'h08, 0, 1, 16'h7FFF));
    load_word(1, enc_i(6'h08, 1, 1, 16'h0001));
    load_word(2, HALT_W);
    do_reset();
    run(0, 0, '0, '0, 60, 1);
    check("ovf_n", strobe_v.size(), 2);
    if (strobe_v.size() == 2) check("ovf_value", strobe_v[1], 16'h8000);

    // Jump to last word (NOP) and pc wraps to 0.
    load_word(0, enc_j(63));
    load_word(63, 32'h0000_0000);
    do_reset();
    run(0, 0, '0, '0, 9, 0);
    check("wrap_pc_last", pc_log[4], 63);
    check("wrap_pc_zero", pc_log[7], 0);
    do_reset();
    load_word(63, HALT_W);

    // Reset during EXEC of an ADD.
    load_word(0, enc_i(6'h08, 1, 1, 16'd5));
    load_word(1, enc_r(1, 1, 2, 6'h20));
    load_word(2, HALT_W);
    do_reset();
    run(7, 3, '0, '0, 20, 0);
    check("rstx_strobes_before", strobe_v.size(), 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstx_valid", result_valid, 0);
    end
    check("rstx_result", result, 0);
    check("rstx_busy", busy, 0);
    check("rstx_halted", halted, 0);
    check("rstx_pc", pc, 0);
    check("rstx_count", instr_count, 0);
    asyn_n_rst = 1'b1;
    @(negedge clk);
    run(0, 0, '0, '0, 60, 1);
    check("rstx_rerun_n", strobe_v.size(), 2);
    if (strobe_v.size() == 2) begin
      check("rstx_rerun_r1", strobe_v[0], 5);
      check("rstx_rerun_add", strobe_v[1], 10);
    end

    // Load/start while busy is ignored; start in HALT reruns.
    load_basic();
    do_reset();
    run(2, 1, 6'd3, enc_i(6'h08, 0, 4, 16'h0055), 60, 1);
    check_strobes4("imwe_busy");
    run(6, 2, '0, '0, 60, 1);
    check_strobes4("start_busy");
    run(0, 0, '0, '0, 60, 1);
    check_strobes4("rerun");
    check("rerun_pc0", pc_log[1], 0);

    // Table-driven single-operation vectors.
    for (int v = 0; v < 10; v++) begin
      load_word(0, enc_i(6'h08, 0, 1, vt[v].a));
      load_word(1, enc_i(6'h08, 0, 2, vt[v].b));
      load_word(2, enc_r(1, 2, 3, vt[v].funct));
      load_word(3, HALT_W);
      do_reset();
      run(0, 0, '0, '0, 40, 1);
      check("vec_n", strobe_v.size(), vt[v].has_wb ? 3 : 2);
      if (vt[v].has_wb && strobe_v.size() == 3) check("vec_value", strobe_v[2], vt[v].expv);
      check("vec_count", instr_count, 4);
    end

    // Random forward-only programs against the model.
    for (int r = 0; r < 25; r++) begin
      L = $urandom_range(4, 16);
      for (int i = 0; i < L; i++) begin
        kind = $urandom_range(0, 9);
        rs = $urandom_range(0, 7);
        rt = $urandom_range(0, 7);
        rd = $urandom_range(0, 7);
        if (kind <= 3)      load_word(i, enc_i(6'h08, rs, rt, 16'($urandom)));
        else if (kind <= 6) load_word(i, enc_r(rs, rt, rd, fn_tab[$urandom_range(0, 5)]));
        else if (kind == 7) load_word(i, enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3))));
        else if (kind == 8) load_word(i, enc_j($urandom_range(i + 1, L)));
        else                load_word(i, enc_i(6'h0B, rs, rt, 16'($urandom)));
      end
      for (int i = L; i <= L + 4; i++) load_word(i, HALT_W);
      do_reset();
      model_run(1);
      run(0, 0, '0, '0, 400, 1);
      compare_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
